multi_digit_7seg: RTL and testbench

MULTI_DIGIT_7SEG -- requirements
Module: multi_digit_7seg

---
 rtl/multi_digit_7seg_if.sv | 23 ++
 rtl/multi_digit_7seg.sv | 118 +++++++++++
 tb/tb_multi_digit_7seg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/multi_digit_7seg_if.sv
// Purpose : display-side signal bundle for multi_digit_7seg (BCD value in, segment/anode drive out).
// Ports   : value/blank_lz/blink_en flow master->slave; seg/an/frame_done flow slave->master.
// Modports: master = the block feeding digits (e.g. a bench or CPU regs); slave = the display driver.
interface multi_digit_7seg_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;       // packed BCD, nibble k -> digit k
  logic                    blank_lz;    // leading-zero blanking enable
  logic [NUM_DIGITS-1:0]   blink_en;    // per-digit blink enable
  logic [6:0]              seg;         // active-low {g,f,e,d,c,b,a}
  logic [NUM_DIGITS-1:0]   an;          // active-low digit enables
  logic                    frame_done;  // one-cycle pulse after each frame wrap

  modport master (
    output value, blank_lz, blink_en,
    input  seg, an, frame_done
  );

  modport slave (
    input  value, blank_lz, blink_en,
    output seg, an, frame_done
  );
endinterface

// File: rtl/multi_digit_7seg.sv
// Purpose : time-multiplexed N-digit 7-segment driver with leading-zero blanking and per-digit blink.
// Latency : seg/an/frame_done are registered, one clk_1k cycle after the scan index/shadow they reflect.
// Backpressure: none; scan and blink counters free-run and never stall.
// Ports   : clk_1k (sole clock), rst_n (sync, active-low), disp (slave modport: value, blank_lz,
//           blink_en in; seg, an, frame_done out).
module multi_digit_7seg #(
  parameter int NUM_DIGITS = 4,    // 2..8
  parameter int SCAN_DIV   = 1,    // 1..1024 clk_1k cycles per digit slot
  parameter int BLINK_DIV  = 500   // 2..65535 clk_1k cycles per blink half-period
) (
  input  logic              clk_1k,
  input  logic              rst_n,
  multi_digit_7seg_if.slave disp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [DW-1:0]         r_div_cnt;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic [VW-1:0]         r_shadow;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  logic                  w_scan_tick;
  logic                  w_frame_wrap;
  logic                  w_blink_wrap;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic [3:0]            w_nibble;
  logic                  w_digit_blank;
  logic [6:0]            w_seg_code;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_scan_tick  = (r_div_cnt == DIV_LAST);
  assign w_frame_wrap = w_scan_tick && (r_idx == IDX_LAST);
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

  // Walk from the most significant digit down: a digit is a leading zero while
  // every nibble from it upward is zero. Digit 0 always stays lit.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run    = w_zero_run & (r_shadow[4*k +: 4] == 4'd0);
      w_lz_blank[k] = disp.blank_lz & w_zero_run & (k != 0);
    end
  end

  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];

  // Blink enables are used live so software can start/stop blinking without
  // waiting for a frame boundary.
  assign w_digit_blank = w_lz_blank[r_idx] | (disp.blink_en[r_idx] & r_blink_phase);

  assign w_an_next = ~(NUM_DIGITS'(1) << r_idx);

  always_comb begin
    w_seg_code = 7'h3F;  // A..F show a dash
    case (w_nibble)
      4'd0:    w_seg_code = 7'h40;
      4'd1:    w_seg_code = 7'h79;
      4'd2:    w_seg_code = 7'h24;
      4'd3:    w_seg_code = 7'h30;
      4'd4:    w_seg_code = 7'h19;
      4'd5:    w_seg_code = 7'h12;
      4'd6:    w_seg_code = 7'h02;
      4'd7:    w_seg_code = 7'h78;
      4'd8:    w_seg_code = 7'h00;
      4'd9:    w_seg_code = 7'h10;
      default: w_seg_code = 7'h3F;
    endcase
  end

  always_ff @(posedge clk_1k) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_shadow      <= '0;
      r_seg         <= 7'h7F;
      r_an          <= '1;
      r_frame_done  <= 1'b0;
    end else begin
      r_div_cnt <= w_scan_tick ? '0 : r_div_cnt + 1'b1;
      if (w_scan_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      // Only capture at the frame boundary so one frame never mixes two values.
      if (w_frame_wrap) begin
        r_shadow <= disp.value;
      end
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      if (w_blink_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
      // A blanked slot keeps its time but lights nothing.
      r_seg        <= w_digit_blank ? 7'h7F : w_seg_code;
      r_an         <= w_digit_blank ? '1 : w_an_next;
      r_frame_done <= w_frame_wrap;
    end
  end

  assign disp.seg        = r_seg;
  assign disp.an         = r_an;
  assign disp.frame_done = r_frame_done;

endmodule

// File: tb/tb_multi_digit_7seg.sv
// Purpose : directed self-checking bench for multi_digit_7seg (4 digits, SCAN_DIV=1, BLINK_DIV=8).
// Timing  : inputs change and outputs are sampled on the falling edge; each step is one rising edge.
// Note    : digit k shows nibble k, so an=E (digit 0) pairs with the least significant nibble.
module tb_multi_digit_7seg;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multi_digit_7seg_if #(.NUM_DIGITS(4)) dif ();

  multi_digit_7seg #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (1),
    .BLINK_DIV (8)
  ) dut (
    .clk_1k(clk),
    .rst_n (rst_n),
    .disp  (dif)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_fd);
    checks++;
    assert (dif.an === e_an) else begin
      errors++;
      $error("FAIL %s an: got %h want %h", tag, dif.an, e_an);
    end
    checks++;
    assert (dif.seg === e_seg) else begin
      errors++;
      $error("FAIL %s seg: got %h want %h", tag, dif.seg, e_seg);
    end
    checks++;
    assert (dif.frame_done === e_fd) else begin
      errors++;
      $error("FAIL %s frame_done: got %b want %b", tag, dif.frame_done, e_fd);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                      input logic e_fd);
    cyc();
    chk(tag, e_an, e_seg, e_fd);
  endtask

  initial begin
    dif.value    = 16'h0000;
    dif.blank_lz = 1'b0;
    dif.blink_en = 4'b0000;

    // Reset
    cyc();
    cyc();
    chk("reset", 4'hF, 7'h7F, 1'b0);

    // First frame after release shows shadow=0 even though value is already 1234
    dif.value = 16'h1234;
    rst_n     = 1'b1;
    step("first_d0", 4'hE, 7'h40, 1'b0);
    step("first_d1", 4'hD, 7'h40, 1'b0);
    step("first_d2", 4'hB, 7'h40, 1'b0);
    step("first_d3", 4'h7, 7'h40, 1'b1);

    // Basic scan of 1234
    step("scan_d0", 4'hE, 7'h19, 1'b0);
    step("scan_d1", 4'hD, 7'h30, 1'b0);
    step("scan_d2", 4'hB, 7'h24, 1'b0);
    step("scan_d3", 4'h7, 7'h79, 1'b1);
    step("scan2_d0", 4'hE, 7'h19, 1'b0);
    step("scan2_d1", 4'hD, 7'h30, 1'b0);

    // Mid-frame change while idx=2: rest of frame still shows 2 and 1
    dif.value = 16'h5678;
    step("mid_d2", 4'hB, 7'h24, 1'b0);
    step("mid_d3", 4'h7, 7'h79, 1'b1);
    step("new_d0", 4'hE, 7'h00, 1'b0);
    step("new_d1", 4'hD, 7'h78, 1'b0);
    step("new_d2", 4'hB, 7'h02, 1'b0);
    step("new_d3", 4'h7, 7'h12, 1'b1);

    // Leading-zero blanking of 0050 (loaded at the next wrap)
    dif.value    = 16'h0050;
    dif.blank_lz = 1'b1;
    step("lzpre_d0", 4'hE, 7'h00, 1'b0);
    step("lzpre_d1", 4'hD, 7'h78, 1'b0);
    step("lzpre_d2", 4'hB, 7'h02, 1'b0);
    step("lzpre_d3", 4'h7, 7'h12, 1'b1);
    step("lz_d0", 4'hE, 7'h40, 1'b0);
    dif.value = 16'h0000;
    step("lz_d1", 4'hD, 7'h12, 1'b0);
    step("lz_d2", 4'hF, 7'h7F, 1'b0);
    step("lz_d3", 4'hF, 7'h7F, 1'b1);

    // All zeros with blanking: only digit 0 lit
    step("zero_d0", 4'hE, 7'h40, 1'b0);
    step("zero_d1", 4'hF, 7'h7F, 1'b0);
    step("zero_d2", 4'hF, 7'h7F, 1'b0);
    step("zero_d3", 4'hF, 7'h7F, 1'b1);

    // Blink digit 0 (live enable; phase is 1 here), then dash on nibble C
    dif.value    = 16'h123C;
    dif.blank_lz = 1'b0;
    dif.blink_en = 4'b0001;
    step("blk_off_d0", 4'hF, 7'h7F, 1'b0);
    step("nolz_d1", 4'hD, 7'h40, 1'b0);
    step("nolz_d2", 4'hB, 7'h40, 1'b0);
    step("nolz_d3", 4'h7, 7'h40, 1'b1);
    step("dash_on_d0", 4'hE, 7'h3F, 1'b0);
    step("dash_d1", 4'hD, 7'h30, 1'b0);
    step("dash_d2", 4'hB, 7'h24, 1'b0);
    step("dash_d3", 4'h7, 7'h79, 1'b1);
    step("dash_on2_d0", 4'hE, 7'h3F, 1'b0);
    cyc();
    cyc();
    cyc();
    step("dash_off_d0", 4'hF, 7'h7F, 1'b0);
    step("steady_d1", 4'hD, 7'h30, 1'b0);
    step("steady_d2", 4'hB, 7'h24, 1'b0);
    step("steady_d3", 4'h7, 7'h79, 1'b1);
    step("dash_off2_d0", 4'hF, 7'h7F, 1'b0);
    cyc();
    cyc();
    step("steady2_d3", 4'h7, 7'h79, 1'b1);
    step("dash_back_d0", 4'hE, 7'h3F, 1'b0);

    // Reset mid-frame for one cycle
    rst_n     = 1'b0;
    dif.value = 16'h9876;
    step("midrst", 4'hF, 7'h7F, 1'b0);
    rst_n = 1'b1;
    step("rec_d0", 4'hE, 7'h40, 1'b0);
    step("rec_d1", 4'hD, 7'h40, 1'b0);
    step("rec_d2", 4'hB, 7'h40, 1'b0);
    step("rec_d3", 4'h7, 7'h40, 1'b1);
    step("rec2_d0", 4'hE, 7'h02, 1'b0);
    step("rec2_d1", 4'hD, 7'h78, 1'b0);
    step("rec2_d2", 4'hB, 7'h00, 1'b0);
    step("rec2_d3", 4'h7, 7'h10, 1'b1);
    step("rec_blink_d0", 4'hF, 7'h7F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
